dec_fpr_sb_ctl: RTL and testbench

DEC_FPR_SB_CTL -- requirements
Module: dec_fpr_sb_ctl

---
 rtl/dec_fpr_pkg.sv | 16 +
 rtl/dec_fpr_sb.sv | 52 +++++
 rtl/dec_fpr_sb_ctl.sv | 120 ++++++++++++
 tb/tb_dec_fpr_sb_ctl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_fpr_pkg.sv
// Shared defaults and scoreboard error causes for the FP register file
// and its busy-bit scoreboard.
package dec_fpr_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int NREGS_DEF    = 32;
    localparam int ZERO_REG_DEF = 1;

    typedef enum logic [1:0] {
        SB_OK       = 2'd0,
        SB_DBL_SET  = 2'd1,
        SB_WB_IDLE  = 2'd2,
        SB_WR_BUSY  = 2'd3
    } sb_cause_e;

endpackage

// File: rtl/dec_fpr_sb.sv
// Busy-bit scoreboard: set on long-latency issue, clear on FPU writeback,
// registered error pulse on inconsistent events.
module dec_fpr_sb
    import dec_fpr_pkg::*;
#(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             set_v,
    input  logic [AW-1:0]    sb_addr,
    input  logic             clr_v,
    input  logic [AW-1:0]    waddr1,
    input  logic             wr0_v,
    input  logic [AW-1:0]    waddr0,
    output logic [DEPTH-1:0] busy_vec,
    output logic             sb_err
);

    logic [DEPTH-1:0] busy_nxt;
    sb_cause_e        cause;

    always_comb begin
        busy_nxt = busy_vec;
        if (clr_v) busy_nxt[waddr1] = 1'b0;
        // set is applied last so it wins a same-address race
        if (set_v) busy_nxt[sb_addr] = 1'b1;
    end

    always_comb begin
        cause = SB_OK;
        if (set_v && busy_vec[sb_addr] &&
            !(clr_v && (waddr1 == sb_addr)))
            cause = SB_DBL_SET;
        else if (clr_v && !busy_vec[waddr1])
            cause = SB_WB_IDLE;
        else if (wr0_v && busy_vec[waddr0])
            cause = SB_WR_BUSY;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            busy_vec <= '0;
            sb_err   <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            sb_err   <= (cause != SB_OK);
        end
    end

endmodule

// File: rtl/dec_fpr_sb_ctl.sv
// FP register file with three bypassed read ports, two write ports
// and a scoreboard that flags sources still waiting on the FPU.
module dec_fpr_sb_ctl
    import dec_fpr_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int AW       = $clog2(NREGS),
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            rden0,
    input  logic            rden1,
    input  logic            rden2,
    input  logic [AW-1:0]   raddr0,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rd0,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            wen0,
    input  logic [AW-1:0]   waddr0,
    input  logic [XLEN-1:0] wd0,
    input  logic            wen1,
    input  logic [AW-1:0]   waddr1,
    input  logic [XLEN-1:0] wd1,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    output logic            busy0,
    output logic            busy1,
    output logic            busy2,
    output logic            stall,
    output logic            sb_err,
    input  logic            scan_mode
);

    localparam int DEPTH = 1 << AW;

    function automatic logic [DEPTH-1:0] ok_mask();
        logic [DEPTH-1:0] m;
        for (int i = 0; i < DEPTH; i++)
            m[i] = (i < NREGS) && !((ZERO_REG != 0) && (i == 0));
        return m;
    endfunction

    // one bit per encodable address: readable and writable
    localparam logic [DEPTH-1:0] OK = ok_mask();

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] busy_vec;
    logic             w0_v, w1_v, set_v;
    logic [2:0]       rden_a;
    logic [AW-1:0]    raddr_a [3];
    logic [XLEN-1:0]  rd_a [3];
    logic [2:0]       busy_a;
    logic             unused_scan;

    assign unused_scan = scan_mode;

    assign w0_v  = wen0 & OK[waddr0];
    assign w1_v  = wen1 & OK[waddr1];
    assign set_v = sb_set & OK[sb_addr];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            if (w1_v) regs[waddr1] <= wd1;
            if (w0_v) regs[waddr0] <= wd0;
        end
    end

    assign rden_a     = {rden2, rden1, rden0};
    assign raddr_a[0] = raddr0;
    assign raddr_a[1] = raddr1;
    assign raddr_a[2] = raddr2;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_a[k]   = '0;
            busy_a[k] = 1'b0;
            if (rst_l && rden_a[k] && OK[raddr_a[k]]) begin
                if (w0_v && (waddr0 == raddr_a[k]))
                    rd_a[k] = wd0;
                else if (w1_v && (waddr1 == raddr_a[k]))
                    rd_a[k] = wd1;
                else
                    rd_a[k] = regs[raddr_a[k]];
                busy_a[k] = busy_vec[raddr_a[k]] &
                            ~(w1_v && (waddr1 == raddr_a[k]));
            end
        end
    end

    assign rd0   = rd_a[0];
    assign rd1   = rd_a[1];
    assign rd2   = rd_a[2];
    assign busy0 = busy_a[0];
    assign busy1 = busy_a[1];
    assign busy2 = busy_a[2];
    assign stall = |busy_a;

    dec_fpr_sb #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_sb (
        .clk      (clk),
        .rst_l    (rst_l),
        .set_v    (set_v),
        .sb_addr  (sb_addr),
        .clr_v    (w1_v),
        .waddr1   (waddr1),
        .wr0_v    (w0_v),
        .waddr0   (waddr0),
        .busy_vec (busy_vec),
        .sb_err   (sb_err)
    );

endmodule

// File: tb/tb_dec_fpr_sb_ctl.sv
// Directed bench for dec_fpr_sb_ctl: reset, bypass, port priority,
// scoreboard set/clear and error pulses, mid-operation reset.
module tb_dec_fpr_sb_ctl;

    logic        clk, rst_l;
    logic        rden0, rden1, rden2;
    logic [4:0]  raddr0, raddr1, raddr2;
    logic [31:0] rd0, rd1, rd2;
    logic        wen0, wen1, sb_set;
    logic [4:0]  waddr0, waddr1, sb_addr;
    logic [31:0] wd0, wd1;
    logic        busy0, busy1, busy2, stall, sb_err;
    logic        scan_mode;

    int checks = 0;
    int failures = 0;

    dec_fpr_sb_ctl dut (
        .clk(clk), .rst_l(rst_l),
        .rden0(rden0), .rden1(rden1), .rden2(rden2),
        .raddr0(raddr0), .raddr1(raddr1), .raddr2(raddr2),
        .rd0(rd0), .rd1(rd1), .rd2(rd2),
        .wen0(wen0), .waddr0(waddr0), .wd0(wd0),
        .wen1(wen1), .waddr1(waddr1), .wd1(wd1),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .busy0(busy0), .busy1(busy1), .busy2(busy2),
        .stall(stall), .sb_err(sb_err), .scan_mode(scan_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wen0 = 0; wen1 = 0; sb_set = 0;
        waddr0 = 0; waddr1 = 0; sb_addr = 0;
        wd0 = 0; wd1 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_l = 0; scan_mode = 0;
        rden0 = 0; rden1 = 0; rden2 = 0;
        raddr0 = 0; raddr1 = 0; raddr2 = 0;
        idle();
        tick();
        // outputs held at zero in reset even with a bypass candidate
        rden0 = 1; rden1 = 1; raddr0 = 5; raddr1 = 5;
        wen0 = 1; waddr0 = 5; wd0 = 32'hDEADBEEF;
        sb_set = 1; sb_addr = 5;
        #1;
        chk("rst_rd0", rd0, 0);
        chk("rst_rd1", rd1, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        tick();
        chk("rst_sberr", {31'd0, sb_err}, 0);
        idle();
        @(negedge clk);
        rst_l = 1;
        rden0 = 1; rden1 = 1; rden2 = 1;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(a); raddr2 = 5'(a);
            #1;
            chk("init_rd0", rd0, 0);
            chk("init_rd1", rd1, 0);
            chk("init_rd2", rd2, 0);
            chk("init_stall", {31'd0, stall}, 0);
        end
        rden1 = 0; rden2 = 0;

        // port-0 write with same-cycle bypass
        tick();
        wen0 = 1; waddr0 = 5; wd0 = 32'h3F800000; raddr0 = 5;
        #1;
        chk("byp_rd0", rd0, 32'h3F800000);
        tick();
        idle();
        #1;
        chk("stored_r5", rd0, 32'h3F800000);

        // zero register ignores writes
        wen0 = 1; waddr0 = 0; wd0 = 32'hFFFFFFFF; raddr0 = 0;
        #1;
        chk("r0_byp", rd0, 0);
        tick();
        idle();
        #1;
        chk("r0_stored", rd0, 0);
        chk("r0_sberr", {31'd0, sb_err}, 0);

        // dual write to one address: port 0 data wins
        wen0 = 1; waddr0 = 7; wd0 = 32'h11111111;
        wen1 = 1; waddr1 = 7; wd1 = 32'h22222222;
        raddr0 = 7;
        #1;
        chk("dual_byp", rd0, 32'h11111111);
        tick();
        chk("dual_sberr", {31'd0, sb_err}, 1);
        idle();
        #1;
        chk("dual_rd", rd0, 32'h11111111);
        tick();
        chk("dual_sberr_end", {31'd0, sb_err}, 0);

        // scoreboard set then writeback release
        sb_set = 1; sb_addr = 9;
        tick();
        idle();
        chk("set9_sberr", {31'd0, sb_err}, 0);
        rden0 = 0; raddr0 = 9; rden1 = 1; raddr1 = 9;
        #1;
        chk("busy1_set", {31'd0, busy1}, 1);
        chk("stall_set", {31'd0, stall}, 1);
        chk("busy0_off", {31'd0, busy0}, 0);
        wen1 = 1; waddr1 = 9; wd1 = 32'h40490FDB;
        #1;
        chk("busy1_rel", {31'd0, busy1}, 0);
        chk("stall_rel", {31'd0, stall}, 0);
        chk("rd1_wb", rd1, 32'h40490FDB);
        tick();
        idle();
        chk("wb9_sberr", {31'd0, sb_err}, 0);
        #1;
        chk("busy1_clr", {31'd0, busy1}, 0);
        chk("rd1_r9", rd1, 32'h40490FDB);

        // port-0 write to a busy address
        sb_set = 1; sb_addr = 10;
        tick();
        idle();
        wen0 = 1; waddr0 = 10; wd0 = 32'h1;
        tick();
        chk("wr_busy_err", {31'd0, sb_err}, 1);
        idle();
        wen1 = 1; waddr1 = 10; wd1 = 32'h2;
        tick();
        chk("wb10_sberr", {31'd0, sb_err}, 0);
        idle();

        // set and clear race on one address: set wins, no error
        sb_set = 1; sb_addr = 11;
        tick();
        sb_set = 1; sb_addr = 11;
        wen1 = 1; waddr1 = 11; wd1 = 32'h3;
        tick();
        chk("race_sberr", {31'd0, sb_err}, 0);
        idle();
        raddr2 = 11; rden2 = 1;
        #1;
        chk("race_busy2", {31'd0, busy2}, 1);
        rden2 = 0;

        // double set to address 3
        sb_set = 1; sb_addr = 3;
        tick();
        chk("dset1_sberr", {31'd0, sb_err}, 0);
        tick();
        chk("dset2_sberr", {31'd0, sb_err}, 1);
        idle();
        tick();
        chk("dset_pulse", {31'd0, sb_err}, 0);

        // writeback to a non-busy address
        wen1 = 1; waddr1 = 4; wd1 = 32'hA5A5A5A5;
        tick();
        chk("idle_wb_err", {31'd0, sb_err}, 1);
        idle();
        raddr1 = 4;
        #1;
        chk("idle_wb_rd", rd1, 32'hA5A5A5A5);
        tick();
        chk("idle_wb_pulse", {31'd0, sb_err}, 0);

        // reset mid-operation drops pending entries
        sb_set = 1; sb_addr = 2;
        tick();
        idle();
        rden0 = 1; raddr0 = 2;
        #1;
        chk("pre_rst_busy", {31'd0, busy0}, 1);
        #2 rst_l = 0;
        #1;
        chk("in_rst_busy", {31'd0, busy0}, 0);
        chk("in_rst_stall", {31'd0, stall}, 0);
        @(negedge clk);
        rst_l = 1;
        #1;
        chk("post_rst_busy", {31'd0, busy0}, 0);
        raddr1 = 5;
        #1;
        chk("post_rst_r5", rd1, 0);
        wen1 = 1; waddr1 = 2; wd1 = 32'hCAFEF00D;
        tick();
        chk("post_rst_err", {31'd0, sb_err}, 1);
        idle();
        #1;
        chk("post_rst_rd", rd0, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
